// File: rtl/adpll_search_ctrl.sv
// ADPLL loop controller: binary search on COARSE, then FINE, then +/-1 phase tracking on FINE.
// Define SEARCH_RESTART_EN to re-acquire from scratch when FINE saturates during tracking.
module adpll_search_ctrl #(
  parameter int CW       = 3,
  parameter int FW       = 6,
  parameter int SETTLE   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic          REF_CLK,
  input  logic          RESET_,
  input  logic          flagU,
  input  logic          flagD,
  output logic [CW-1:0] COARSE,
  output logic [FW-1:0] FINE,
  output logic          freq_lock,
  output logic          phase_lock
);

  localparam int SW   = $clog2(SETTLE + 1);
  localparam int LW   = $clog2(LOCK_CNT + 1);
  localparam int MAXW = (CW > FW) ? CW : FW;
  localparam int BW   = $clog2(MAXW + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_CNT);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [FW-1:0] F_ONE       = FW'(1);
  localparam logic [CW-1:0] C_TOP       = C_ONE << (CW - 1);
  localparam logic [FW-1:0] F_TOP       = F_ONE << (FW - 1);
  localparam logic [FW-1:0] F_MAX       = {FW{1'b1}};

  typedef enum logic [1:0] {IDLE, CSRCH, FSRCH, TRACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] coarse_q, coarse_d;
  logic [FW-1:0] fine_q, fine_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [BW-1:0] bitIdx_q, bitIdx_d;
  logic          freqLock_q, freqLock_d;
  logic          phaseLock_q, phaseLock_d;
  logic [1:0]    uSync_q, dSync_q;

  logic          sample, uOnly, dOnly, sat;
  logic [CW-1:0] cTrial;
  logic [FW-1:0] fTrial;

  // PFD flags are asynchronous levels; the sync latency is absorbed by the settle window
  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) begin
      uSync_q <= '0;
      dSync_q <= '0;
    end else begin
      uSync_q <= {uSync_q[0], flagU};
      dSync_q <= {dSync_q[0], flagD};
    end
  end

  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q     <= IDLE;
      coarse_q    <= '0;
      fine_q      <= '0;
      settle_q    <= '0;
      lock_q      <= '0;
      bitIdx_q    <= '0;
      freqLock_q  <= 1'b0;
      phaseLock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coarse_q    <= coarse_d;
      fine_q      <= fine_d;
      settle_q    <= settle_d;
      lock_q      <= lock_d;
      bitIdx_q    <= bitIdx_d;
      freqLock_q  <= freqLock_d;
      phaseLock_q <= phaseLock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coarse_d    = coarse_q;
    fine_d      = fine_q;
    settle_d    = settle_q;
    lock_d      = lock_q;
    bitIdx_d    = bitIdx_q;
    freqLock_d  = freqLock_q;
    phaseLock_d = phaseLock_q;
    sat         = 1'b0;
    sample      = (settle_q == '0);
    uOnly       = uSync_q[1] & ~dSync_q[1];
    dOnly       = dSync_q[1] & ~uSync_q[1];
    cTrial      = C_ONE << bitIdx_q;
    fTrial      = F_ONE << bitIdx_q;

    if (state_q != IDLE) begin
      settle_d = sample ? SETTLE_LAST : settle_q - SW'(1);
    end

    case (state_q)
      IDLE: begin
        coarse_d = C_TOP;
        fine_d   = '0;
        bitIdx_d = BW'(CW - 1);
        settle_d = SETTLE_LAST;
        state_d  = CSRCH;
      end
      CSRCH: if (sample) begin
        // A tie or no decision keeps the trial bit set
        if (dOnly) coarse_d = coarse_q & ~cTrial;
        if (bitIdx_q == '0) begin
          fine_d   = F_TOP;
          bitIdx_d = BW'(FW - 1);
          state_d  = FSRCH;
        end else begin
          coarse_d = coarse_d | (cTrial >> 1);
          bitIdx_d = bitIdx_q - BW'(1);
        end
      end
      FSRCH: if (sample) begin
        if (dOnly) fine_d = fine_q & ~fTrial;
        if (bitIdx_q == '0) begin
          freqLock_d = 1'b1;
          lock_d     = '0;
          state_d    = TRACK;
        end else begin
          fine_d   = fine_d | (fTrial >> 1);
          bitIdx_d = bitIdx_q - BW'(1);
        end
      end
      TRACK: if (sample) begin
        if (uOnly) begin
          if (fine_q == F_MAX) sat = 1'b1;
          else fine_d = fine_q + F_ONE;
          lock_d      = '0;
          phaseLock_d = 1'b0;
        end else if (dOnly) begin
          if (fine_q == '0) sat = 1'b1;
          else fine_d = fine_q - F_ONE;
          lock_d      = '0;
          phaseLock_d = 1'b0;
        end else begin
          if (lock_q != LOCK_MAX) lock_d = lock_q + LW'(1);
          if (lock_d == LOCK_MAX) phaseLock_d = 1'b1;
        end
`ifdef SEARCH_RESTART_EN
        if (sat) begin
          coarse_d   = C_TOP;
          fine_d     = '0;
          bitIdx_d   = BW'(CW - 1);
          freqLock_d = 1'b0;
          state_d    = CSRCH;
        end
`else
        // FINE is already held at the rail; only the lock bookkeeping is affected
        if (sat) begin
          lock_d      = '0;
          phaseLock_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign COARSE     = coarse_q;
  assign FINE       = fine_q;
  assign freq_lock  = freqLock_q;
  assign phase_lock = phaseLock_q;

endmodule

// File: tb/tb_adpll_search_ctrl.sv
// Directed bench for adpll_search_ctrl: table-driven search/track checkpoints plus reset,
// tie and saturation sequences. Saturation expectations follow SEARCH_RESTART_EN.
module tb_adpll_search_ctrl;

  logic       REF_CLK = 1'b0;
  logic       RESET_  = 1'b0;
  logic       flagU, flagD;
  logic [2:0] COARSE;
  logic [5:0] FINE;
  logic       freq_lock, phase_lock;

  typedef enum int {M_MODEL, M_NONE, M_U, M_D, M_BOTH} mode_t;
  mode_t mode = M_NONE;

  typedef struct {
    string      name;
    mode_t      mode;
    int         edgeN;
    logic [2:0] c;
    logic [5:0] f;
    logic       fl;
    logic       pl;
  } vec_t;

  vec_t vecs[15];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  adpll_search_ctrl dut (
    .REF_CLK   (REF_CLK),
    .RESET_    (RESET_),
    .flagU     (flagU),
    .flagD     (flagD),
    .COARSE    (COARSE),
    .FINE      (FINE),
    .freq_lock (freq_lock),
    .phase_lock(phase_lock)
  );

  // PFD stand-in: the model mode compares the DCO code against the target {5,42}
  assign flagU = (mode == M_MODEL) ? ({COARSE, FINE} < 9'd362) : (mode == M_U || mode == M_BOTH);
  assign flagD = (mode == M_MODEL) ? ({COARSE, FINE} > 9'd362) : (mode == M_D || mode == M_BOTH);

  always #5 REF_CLK = ~REF_CLK;

  task automatic checkOutput(input string name, input logic [2:0] c, input logic [5:0] f,
                             input logic fl, input logic pl);
    logic [10:0] expv, actv;
    expv = {c, f, fl, pl};
    actv = {COARSE, FINE, freq_lock, phase_lock};
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got COARSE=%0d FINE=%0d freq_lock=%b phase_lock=%b, want COARSE=%0d FINE=%0d freq_lock=%b phase_lock=%b",
               name, COARSE, FINE, freq_lock, phase_lock, c, f, fl, pl);
    end
  endtask

  task automatic applyStimulus(input mode_t m, input int n);
    mode = m;
    while (cycle < n) begin
      @(posedge REF_CLK);
      cycle++;
    end
    #1;
  endtask

  task automatic doReset(input mode_t m);
    mode   = m;
    RESET_ = 1'b0;
    repeat (2) @(posedge REF_CLK);
    @(negedge REF_CLK);
    RESET_ = 1'b1;
    cycle  = 0;
  endtask

  initial begin
    vecs[0]  = '{"t2_reset",      M_MODEL, 0,  3'd0, 6'd0,  1'b0, 1'b0};
    vecs[1]  = '{"t2_idle_exit",  M_MODEL, 1,  3'd4, 6'd0,  1'b0, 1'b0};
    vecs[2]  = '{"t2_settle_hold",M_MODEL, 4,  3'd4, 6'd0,  1'b0, 1'b0};
    vecs[3]  = '{"t2_c_bit2",     M_MODEL, 5,  3'd6, 6'd0,  1'b0, 1'b0};
    vecs[4]  = '{"t2_c_bit1",     M_MODEL, 9,  3'd5, 6'd0,  1'b0, 1'b0};
    vecs[5]  = '{"t2_c_bit0",     M_MODEL, 13, 3'd5, 6'd32, 1'b0, 1'b0};
    vecs[6]  = '{"t2_f_bit5",     M_MODEL, 17, 3'd5, 6'd48, 1'b0, 1'b0};
    vecs[7]  = '{"t2_f_bit4",     M_MODEL, 21, 3'd5, 6'd40, 1'b0, 1'b0};
    vecs[8]  = '{"t2_f_bit3",     M_MODEL, 25, 3'd5, 6'd44, 1'b0, 1'b0};
    vecs[9]  = '{"t2_f_bit2",     M_MODEL, 29, 3'd5, 6'd42, 1'b0, 1'b0};
    vecs[10] = '{"t2_f_bit1_tie", M_MODEL, 33, 3'd5, 6'd43, 1'b0, 1'b0};
    vecs[11] = '{"t2_pre_lock",   M_MODEL, 36, 3'd5, 6'd43, 1'b0, 1'b0};
    vecs[12] = '{"t2_freq_lock",  M_MODEL, 37, 3'd5, 6'd42, 1'b1, 1'b0};
    vecs[13] = '{"t3_lock_7",     M_NONE,  68, 3'd5, 6'd42, 1'b1, 1'b0};
    vecs[14] = '{"t3_lock_8",     M_NONE,  69, 3'd5, 6'd42, 1'b1, 1'b1};

    // T2/T3: model-driven search, then phase lock with quiet flags
    doReset(M_MODEL);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].edgeN);
      checkOutput(vecs[i].name, vecs[i].c, vecs[i].f, vecs[i].fl, vecs[i].pl);
    end

    // T3: one tracking sample sees flagD
    applyStimulus(M_D, 72);
    checkOutput("t3_d_pre", 3'd5, 6'd42, 1'b1, 1'b1);
    applyStimulus(M_D, 73);
    checkOutput("t3_d_step", 3'd5, 6'd41, 1'b1, 1'b0);
    applyStimulus(M_NONE, 77);
    checkOutput("t3_d_after", 3'd5, 6'd41, 1'b1, 1'b0);

    // T1: flagU held to the top rail
    doReset(M_U);
    applyStimulus(M_U, 37);
    checkOutput("t1_lock", 3'd7, 6'd63, 1'b1, 1'b0);
    applyStimulus(M_U, 41);
`ifdef SEARCH_RESTART_EN
    checkOutput("t1_sat", 3'd4, 6'd0, 1'b0, 1'b0);
`else
    checkOutput("t1_sat", 3'd7, 6'd63, 1'b1, 1'b0);
`endif

    // T4: both flags held -> ties keep trial bits, tracking holds FINE
    doReset(M_BOTH);
    applyStimulus(M_BOTH, 37);
    checkOutput("t4_lock", 3'd7, 6'd63, 1'b1, 1'b0);
    applyStimulus(M_BOTH, 68);
    checkOutput("t4_lock_7", 3'd7, 6'd63, 1'b1, 1'b0);
    applyStimulus(M_BOTH, 69);
    checkOutput("t4_lock_8", 3'd7, 6'd63, 1'b1, 1'b1);

    // T5: asynchronous reset in the middle of the FINE search
    doReset(M_U);
    applyStimulus(M_U, 20);
    checkOutput("t5_mid_fsrch", 3'd7, 6'd48, 1'b0, 1'b0);
    #2 RESET_ = 1'b0;
    #1 checkOutput("t5_async_rst", 3'd0, 6'd0, 1'b0, 1'b0);
    @(negedge REF_CLK);
    RESET_ = 1'b1;
    cycle  = 0;
    applyStimulus(M_U, 36);
    checkOutput("t5_pre_lock", 3'd7, 6'd63, 1'b0, 1'b0);
    applyStimulus(M_U, 37);
    checkOutput("t5_lock", 3'd7, 6'd63, 1'b1, 1'b0);

    // T6: flagD held to the bottom rail
    doReset(M_D);
    applyStimulus(M_D, 37);
    checkOutput("t6_lock", 3'd0, 6'd0, 1'b1, 1'b0);
    applyStimulus(M_D, 41);
`ifdef SEARCH_RESTART_EN
    checkOutput("t6_sat", 3'd4, 6'd0, 1'b0, 1'b0);
`else
    checkOutput("t6_sat", 3'd0, 6'd0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
